// File: rtl/phase_osc.sv
// Phase-controlled square-wave oscillator: a prescaled step counter whose output
// is delayed by phi_active steps; new phases are only applied at the period wrap.
module phase_osc #(
    parameter int PHASE_W = 4,
    parameter int DIV_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [DIV_W-1:0]   div,
    input  logic [PHASE_W-1:0] phi_in,
    input  logic               phi_valid,
    output logic               osc_out,
    output logic               full_tick,
    output logic [PHASE_W-1:0] step_cnt,
    output logic [PHASE_W-1:0] phi_active,
    output logic               pending
);

    logic [DIV_W-1:0]   presc;
    logic [PHASE_W-1:0] pend_phi;

    logic               step_tick;
    logic               wrap;
    logic [DIV_W-1:0]   presc_next;
    logic [PHASE_W-1:0] step_next;
    logic [PHASE_W-1:0] phi_next;
    logic [PHASE_W-1:0] pend_phi_next;
    logic               pending_next;
    logic [PHASE_W-1:0] phase_diff;

    // >= rather than == so that shrinking div mid-count can never overrun.
    always_comb begin
        step_tick     = en && (presc >= div);
        wrap          = step_tick && (step_cnt == '1);
        presc_next    = presc;
        step_next     = step_cnt;
        phi_next      = phi_active;
        pend_phi_next = pend_phi;
        pending_next  = pending;

        if (en) begin
            presc_next = step_tick ? '0 : presc + DIV_W'(1);
        end
        if (step_tick) begin
            step_next = step_cnt + PHASE_W'(1);
        end

        if (wrap) begin
            if (phi_valid) begin
                phi_next     = phi_in;
                pending_next = 1'b0;
            end else if (pending) begin
                phi_next     = pend_phi;
                pending_next = 1'b0;
            end
        end else if (phi_valid) begin
            pend_phi_next = phi_in;
            pending_next  = 1'b1;
        end

        phase_diff = step_next - phi_next;
    end

    // osc_out is derived from next-state values so it lines up with step_cnt/phi_active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            step_cnt   <= '0;
            phi_active <= '0;
            pend_phi   <= '0;
            pending    <= 1'b0;
            full_tick  <= 1'b0;
            osc_out    <= 1'b1;
        end else begin
            presc      <= presc_next;
            step_cnt   <= step_next;
            phi_active <= phi_next;
            pend_phi   <= pend_phi_next;
            pending    <= pending_next;
            full_tick  <= wrap;
            osc_out    <= ~phase_diff[PHASE_W-1];
        end
    end

endmodule

// File: tb/tb_phase_osc.sv
// Self-checking bench for phase_osc: directed scenarios plus random stimulus,
// compared every cycle against an arithmetic reference model.
module tb_phase_osc;

    localparam int PHASE_W = 4;
    localparam int DIV_W   = 8;
    localparam int N       = 1 << PHASE_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic [DIV_W-1:0]   div = '0;
    logic [PHASE_W-1:0] phi_in = '0;
    logic               phi_valid = 1'b0;
    logic               osc_out;
    logic               full_tick;
    logic [PHASE_W-1:0] step_cnt;
    logic [PHASE_W-1:0] phi_active;
    logic               pending;

    int check_count = 0;
    int pass_count  = 0;

    int m_presc, m_step, m_active, m_pend_val;
    bit m_pend, m_tick;

    phase_osc #(.PHASE_W(PHASE_W), .DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div       (div),
        .phi_in    (phi_in),
        .phi_valid (phi_valid),
        .osc_out   (osc_out),
        .full_tick (full_tick),
        .step_cnt  (step_cnt),
        .phi_active(phi_active),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_presc = 0; m_step = 0; m_active = 0; m_pend_val = 0;
        m_pend = 0; m_tick = 0;
    endtask

    // Period bookkeeping in plain integers: a step every div+1 enabled clocks,
    // phase changes only take effect at the end of step N-1.
    task automatic model_clock();
        bit tick, wrap;
        tick = en && (m_presc >= int'(div));
        if (en) m_presc = tick ? 0 : m_presc + 1;
        wrap = tick && (m_step == N - 1);
        if (tick) m_step = (m_step + 1) % N;
        if (wrap) begin
            if (phi_valid) begin
                m_active = int'(phi_in);
                m_pend = 0;
            end else if (m_pend) begin
                m_active = m_pend_val;
                m_pend = 0;
            end
        end else if (phi_valid) begin
            m_pend_val = int'(phi_in);
            m_pend = 1;
        end
        m_tick = wrap;
    endtask

    function automatic bit model_osc();
        return ((m_step + N - m_active) % N) < N / 2;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    endtask

    task automatic check_all();
        checkOutput("step_cnt",   16'(step_cnt),   16'(m_step));
        checkOutput("phi_active", 16'(phi_active), 16'(m_active));
        checkOutput("pending",    16'(pending),    16'(m_pend));
        checkOutput("full_tick",  16'(full_tick),  16'(m_tick));
        checkOutput("osc_out",    16'(osc_out),    16'(model_osc()));
    endtask

    task automatic applyStimulus(input bit en_v, input int div_v, input bit valid_v, input int phi_v);
        en        = en_v;
        div       = DIV_W'(div_v);
        phi_valid = valid_v;
        phi_in    = PHASE_W'(phi_v);
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic run_cycles(input bit en_v, input int div_v, input int n);
        for (int i = 0; i < n; i++) applyStimulus(en_v, div_v, 1'b0, 0);
    endtask

    // Advance (div=0) until the model shows the requested step; bounded.
    task automatic run_to_step(input int target);
        int guard;
        guard = 0;
        while (m_step != target && guard < 4 * N) begin
            applyStimulus(1'b1, 0, 1'b0, 0);
            guard++;
        end
        checkOutput("reach_step", 16'(m_step), 16'(target));
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        $display("[TB] free run, div=0");
        run_cycles(1'b1, 0, 40);

        $display("[TB] phase update to 4");
        run_to_step(6);
        applyStimulus(1'b1, 0, 1'b1, 4);
        run_cycles(1'b1, 0, 40);

        $display("[TB] coincident strobe and wrap");
        applyStimulus(1'b1, 0, 1'b1, 3);
        run_to_step(15);
        applyStimulus(1'b1, 0, 1'b1, 9);
        checkOutput("bypass_active", 16'(phi_active), 16'd9);
        checkOutput("bypass_pending", 16'(pending), 16'd0);
        run_cycles(1'b1, 0, 40);

        $display("[TB] prescaler div=3 then div=1");
        run_cycles(1'b1, 3, 140);
        begin
            int guard;
            guard = 0;
            while (m_presc != 3 && guard < 10) begin
                applyStimulus(1'b1, 3, 1'b0, 0);
                guard++;
            end
        end
        run_cycles(1'b1, 1, 50);

        $display("[TB] enable gating");
        run_to_step(5);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 0, (i == 7), 2);
        checkOutput("gated_step", 16'(step_cnt), 16'd5);
        run_cycles(1'b1, 0, 30);
        checkOutput("gated_apply", 16'(phi_active), 16'd2);

        $display("[TB] random stimulus");
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(0, 9) != 0), $urandom_range(0, 3),
                          ($urandom_range(0, 9) == 0), $urandom_range(0, N - 1));
        end

        $display("[TB] async reset mid-period");
        run_to_step(14);
        applyStimulus(1'b1, 0, 1'b1, 7);
        run_to_step(2);
        applyStimulus(1'b1, 0, 1'b1, 5);
        run_to_step(10);
        checkOutput("pre_reset_active", 16'(phi_active), 16'd7);
        checkOutput("pre_reset_pending", 16'(pending), 16'd1);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #1 rst_n = 1'b1;
        run_cycles(1'b1, 0, 20);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/phase_osc.md
Name: phase_osc

Overview:
- Phase-controlled oscillator stage, directly downstream of the per-neuron phase register.
- Consumes the registered phase (phi_in) and its change strobe (phi_valid).
- Produces the neuron's square-wave oscillation, delayed by phi_active steps out of a 2^PHASE_W-step period.
- Emits a one-cycle full_tick at each period wrap; the phase register and neighbouring coupling logic use it as the period boundary.

Parameters:
- PHASE_W, 4: phase width; the period is N = 2^PHASE_W steps.
- DIV_W, 8: prescaler width; each step lasts div+1 clock cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; 0 freezes the oscillator.
- div  in  DIV_W  clocks per step minus 1.
- phi_in  in  PHASE_W  new phase value from the phase register.
- phi_valid  in  1  one-cycle strobe: phi_in has changed.
- osc_out  out  1  oscillator square wave, registered.
- full_tick  out  1  one-cycle pulse on the period wrap.
- step_cnt  out  PHASE_W  current step within the period.
- phi_active  out  PHASE_W  phase currently applied to osc_out.
- pending  out  1  a captured phase is waiting for the next wrap.

Behaviour:
- Reset (async, rst_n=0):
  - Prescaler, step_cnt, phi_active and the internal pending phase all go to 0.
  - pending=0, full_tick=0, osc_out=1 (consistent with the osc_out rule at step 0, phase 0).
- Prescaler:
  - When en=1, it counts 0..div; step_tick is asserted in the cycle where presc>=div, and presc returns to 0.
  - presc>=div (not ==) is the terminal test, so reducing div mid-count takes effect within 1 cycle and never overruns.
  - div=0 gives a step every clock.
- Step counter:
  - On step_tick, step_cnt increments modulo N (N-1 -> 0 wraps).
  - wrap = step_tick AND step_cnt==N-1.
- full_tick:
  - Registered; 1 in the cycle after wrap, when step_cnt first shows 0. Otherwise 0.
  - Exactly one pulse per period; never asserted while en=0.
- Phase capture:
  - On phi_valid=1 (regardless of en), phi_in is stored in the pending phase and pending is set to 1.
  - Multiple strobes before a wrap: the last one wins.
- Phase apply:
  - On wrap with pending=1, phi_active takes the pending phase and pending clears.
  - If phi_valid and wrap coincide, phi_in is applied directly to phi_active and pending ends at 0. This bypass holds even if an older value was pending.
  - phi_active never changes mid-period, so there are no runt pulses at phase updates.
- osc_out:
  - Registered, computed from the next-state step_cnt and phi_active, so it is aligned with the visible step_cnt/phi_active.
  - osc_out = 1 iff ((step_cnt - phi_active) mod N) < N/2. The subtraction is PHASE_W-bit unsigned with natural wrap.
  - Duty cycle is exactly 50%; an edge lands at step phi_active and at (phi_active+N/2) mod N.
- en=0:
  - presc, step_cnt, phi_active and osc_out hold; full_tick=0.
  - Phase capture still operates; the apply is deferred to the first wrap after en returns to 1.
- Reset mid-operation: every state returns to its reset value immediately. A pending phase is discarded.
- Latency:
  - phi_valid to phi_active: at most N*(div+1) clocks, and at least the 0-cycle bypass at wrap.
  - step_cnt to osc_out: 0 cycles (same-cycle aligned).

Test Plan:
- Free run: reset, en=1, div=0, no phi_valid -> step_cnt cycles 0..15 each clock; osc_out=1 for steps 0-7 and 0 for steps 8-15; full_tick pulses every 16 clocks, in the cycle step_cnt=0.
- Phase update: div=0, strobe phi_valid with phi_in=4 at step 6 -> pending=1 and phi_active stays 0 until the wrap; from the next period osc_out=1 for steps 4-11 and pending=0.
- Coincident strobe and wrap: pending phase 3 captured earlier, then phi_valid with phi_in=9 in the wrap cycle (step 15, step_tick) -> phi_active=9 at step 0, pending=0, osc_out=1 for steps 9-15 and 0-0.
- Prescaler: div=3 -> each step lasts 4 clocks and full_tick repeats every 64 clocks; change div to 1 while presc=3 -> presc returns to 0 next cycle and subsequent steps last 2 clocks.
- Enable gating: deassert en at step 5 for 20 clocks while strobing phi_in=2 -> step_cnt holds 5, osc_out holds, no full_tick; after en=1 resumes, phase 2 applies at the next wrap.
- Async reset mid-period: rst_n low at step 10 with phi_active=7 and pending=1 -> step_cnt=0, phi_active=0, pending=0, osc_out=1 and full_tick=0 immediately, without waiting for a clock edge.
